// File: rtl/id_pkg.sv
// id_pkg: decode constants, control encodings and the decoded control bundle
package id_pkg;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR   = 4'b0011,
      ALU_XOR = 4'b0100, ALU_SLT = 4'b0101, ALU_SRA = 4'b0110, ALU_SRL  = 4'b0111,
      ALU_SLL = 4'b1000, ALU_SLTU = 4'b1001
   } alu_t;
   typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_IMM = 2'b11} res_t;
   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_t;
   typedef struct packed {
      logic reg_write;
      logic mem_write;
      logic alu_src;
      logic branch;
      logic jump;
      logic illegal;
      logic use_rs1;
      logic use_rs2;
      res_t result_src;
      alu_t alu_ctrl;
      imm_t imm_type;
   } ctrl_t;
   // alt selects sub (funct3 000) or sra (funct3 101); callers gate it per opcode
   function automatic alu_t alu_decode(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: ID/EX pipeline register bundle
// master: driven by id_stage; slave: consumed by EX
interface id_stage_if #(parameter int XLEN = 32, parameter int RAW = 5, parameter int PCW = 5);
   logic            ex_valid, ex_mem_write, ex_alu_src, ex_reg_write, ex_branch, ex_jump, ex_illegal;
   logic [1:0]      ex_result_src;
   logic [3:0]      ex_alu_ctrl;
   logic [2:0]      ex_funct3;
   logic [XLEN-1:0] ex_rd1, ex_rd2, ex_imm;
   logic [RAW-1:0]  ex_rs1, ex_rs2, ex_rd;
   logic [PCW-1:0]  ex_pc, ex_pc_next;
   modport master (output ex_valid, ex_mem_write, ex_alu_src, ex_reg_write, ex_branch, ex_jump,
                   ex_illegal, ex_result_src, ex_alu_ctrl, ex_funct3, ex_rd1, ex_rd2, ex_imm,
                   ex_rs1, ex_rs2, ex_rd, ex_pc, ex_pc_next);
   modport slave  (input  ex_valid, ex_mem_write, ex_alu_src, ex_reg_write, ex_branch, ex_jump,
                   ex_illegal, ex_result_src, ex_alu_ctrl, ex_funct3, ex_rd1, ex_rd2, ex_imm,
                   ex_rs1, ex_rs2, ex_rd, ex_pc, ex_pc_next);
endinterface

// File: rtl/id_regfile.sv
// id_regfile: NREG x XLEN register file, x0 hardwired to zero, writeback bypass on reads
// ports: clk, reset; wb_en/wb_addr/wb_data write port; ra1/ra2 read addresses -> rd1/rd2
module id_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int RAW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wb_en,
   input  logic [RAW-1:0]  wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic [RAW-1:0]  ra1,
   input  logic [RAW-1:0]  ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);
   logic [XLEN-1:0] regs [NREG];
   logic            wr;
   assign wr = wb_en && wb_addr != '0;
   always_ff @(posedge clk) begin
      if (reset)
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      else if (wr)
         regs[wb_addr] <= wb_data;
   end
   assign rd1 = ra1 == '0 ? '0 : (wr && wb_addr == ra1) ? wb_data : regs[ra1];
   assign rd2 = ra2 == '0 ? '0 : (wr && wb_addr == ra2) ? wb_data : regs[ra2];
endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode, immediate generation, load-use hazard detection, ID/EX register
// ports: clk, reset; instr/in_valid/pc/pc_next from IF/ID; stall_in, flush from EX/branch unit;
//        wb_* writeback port; load_use_stall to IF; ex (id_stage_if.master) ID/EX outputs
module id_stage
   import id_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int PCW  = 5,
   localparam int RAW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     instr,
   input  logic            in_valid,
   input  logic [PCW-1:0]  pc,
   input  logic [PCW-1:0]  pc_next,
   input  logic            stall_in,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [RAW-1:0]  wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            load_use_stall,
   id_stage_if.master      ex
);
   logic [6:0]      op;
   logic [2:0]      f3;
   logic [RAW-1:0]  rs1, rs2, rd;
   logic [XLEN-1:0] rd1, rd2, imm;
   ctrl_t           c, ctl;
   logic            hazard, bubble;
   assign op  = instr[6:0];
   assign f3  = instr[14:12];
   assign rs1 = instr[15+:RAW];
   assign rs2 = instr[20+:RAW];
   assign rd  = instr[7+:RAW];
   id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
      .clk(clk), .reset(reset), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ra1(rs1), .ra2(rs2), .rd1(rd1), .rd2(rd2)
   );
   always_comb begin
      c = '0;
      case (op)
         OP_LW:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.result_src = RES_MEM; c.imm_type = IMM_I; c.use_rs1 = 1'b1; end
         OP_SW:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.imm_type = IMM_S; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
         OP_R:   begin c.reg_write = 1'b1; c.alu_ctrl = alu_decode(f3, instr[30]); c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
         OP_BR:  begin c.branch = 1'b1; c.alu_ctrl = ALU_SUB; c.imm_type = IMM_B; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
         // bit 30 is immediate data for addi etc.; only shifts-right reuse it as sra select
         OP_I:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_ctrl = alu_decode(f3, f3 == 3'b101 && instr[30]); c.imm_type = IMM_I; c.use_rs1 = 1'b1; end
         OP_JAL: begin c.reg_write = 1'b1; c.jump = 1'b1; c.result_src = RES_PC4; c.imm_type = IMM_J; end
         OP_LUI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.result_src = RES_IMM; c.imm_type = IMM_U; end
         default: c.illegal = 1'b1;
      endcase
   end
   assign ctl = in_valid ? c : '0;
   always_comb begin
      imm = ctl.imm_type == IMM_I ? {{(XLEN-11){instr[31]}}, instr[30:20]} :
            ctl.imm_type == IMM_S ? {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]} :
            ctl.imm_type == IMM_B ? {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
            ctl.imm_type == IMM_J ? {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
            ctl.imm_type == IMM_U ? {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0} : '0;
   end
   assign hazard = ex.ex_valid && ex.ex_result_src == RES_MEM && ex.ex_rd != '0 && in_valid &&
                   ((c.use_rs1 && rs1 == ex.ex_rd) || (c.use_rs2 && rs2 == ex.ex_rd));
   assign load_use_stall = hazard && !flush;
   // stall_in outranks the load-use bubble: a held EX stage keeps its instruction
   assign bubble = reset || flush || (!stall_in && hazard);
   always_ff @(posedge clk) begin
      if (bubble) begin
         ex.ex_valid      <= 1'b0;
         ex.ex_mem_write  <= 1'b0;
         ex.ex_alu_src    <= 1'b0;
         ex.ex_reg_write  <= 1'b0;
         ex.ex_branch     <= 1'b0;
         ex.ex_jump       <= 1'b0;
         ex.ex_illegal    <= 1'b0;
         ex.ex_result_src <= '0;
         ex.ex_alu_ctrl   <= '0;
         ex.ex_funct3     <= '0;
         ex.ex_rd1        <= '0;
         ex.ex_rd2        <= '0;
         ex.ex_imm        <= '0;
         ex.ex_rs1        <= '0;
         ex.ex_rs2        <= '0;
         ex.ex_rd         <= '0;
         ex.ex_pc         <= '0;
         ex.ex_pc_next    <= '0;
      end else if (!stall_in) begin
         ex.ex_valid      <= in_valid;
         ex.ex_mem_write  <= ctl.mem_write;
         ex.ex_alu_src    <= ctl.alu_src;
         ex.ex_reg_write  <= ctl.reg_write;
         ex.ex_branch     <= ctl.branch;
         ex.ex_jump       <= ctl.jump;
         ex.ex_illegal    <= ctl.illegal;
         ex.ex_result_src <= ctl.result_src;
         ex.ex_alu_ctrl   <= ctl.alu_ctrl;
         ex.ex_funct3     <= (in_valid && !c.illegal) ? f3 : 3'b0;
         ex.ex_rd1        <= rd1;
         ex.ex_rd2        <= rd2;
         ex.ex_imm        <= imm;
         ex.ex_rs1        <= rs1;
         ex.ex_rs2        <= rs2;
         ex.ex_rd         <= rd;
         ex.ex_pc         <= pc;
         ex.ex_pc_next    <= pc_next;
      end
   end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage
module tb_id_stage;
   logic        clk = 1'b0;
   logic        reset, in_valid, stall_in, flush, wb_en, load_use_stall;
   logic [31:0] instr, wb_data;
   logic [4:0]  pc, pc_next, wb_addr;
   int          checks = 0;
   int          errors = 0;

   id_stage_if #(.XLEN(32), .RAW(5), .PCW(5)) ex ();

   id_stage #(.XLEN(32), .NREG(32), .PCW(5)) dut (
      .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid), .pc(pc), .pc_next(pc_next),
      .stall_in(stall_in), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .load_use_stall(load_use_stall), .ex(ex)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, r2, r1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, r1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2, input logic [4:0] r1);
      return {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2, input logic [4:0] r1);
      return {imm[12], imm[10:5], r2, r1, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; in_valid = 0; stall_in = 0; flush = 0; wb_en = 0;
      instr = 0; wb_data = 0; wb_addr = 0; pc = 0; pc_next = 0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1; flush = 1; stall_in = 1; in_valid = 1; instr = enc_r(0, 0, 3, 0, 1);
      wb_en = 1; wb_addr = 3; wb_data = 32'hDEAD_BEEF;
      tick(); tick();
      checks++; if (ex.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ex.ex_valid); end
      checks++; if (ex.ex_reg_write !== 1'b0 || ex.ex_rd !== 5'd0 || ex.ex_imm !== 32'd0 || ex.ex_rd1 !== 32'd0)
         begin errors++; $display("FAIL reset_outputs got rw=%b rd=%h imm=%h rd1=%h exp all 0", ex.ex_reg_write, ex.ex_rd, ex.ex_imm, ex.ex_rd1); end
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", load_use_stall); end
      idle();
      in_valid = 1; instr = enc_r(0, 0, 3, 0, 1);
      tick();
      checks++; if (ex.ex_rd1 !== 32'd0) begin errors++; $display("FAIL reset_discards_write got %h exp 0", ex.ex_rd1); end
      checks++; if (ex.ex_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid got %b exp 1", ex.ex_valid); end
   endtask

   task automatic test_bypass();
      idle();
      in_valid = 1; instr = enc_r(0, 0, 5, 0, 6); pc = 5'd4; pc_next = 5'd8;
      wb_en = 1; wb_addr = 5; wb_data = 32'h1234;
      tick();
      checks++; if (ex.ex_rd1 !== 32'h1234) begin errors++; $display("FAIL bypass_rd1 got %h exp 00001234", ex.ex_rd1); end
      checks++; if (ex.ex_rd !== 5'd6 || ex.ex_rs1 !== 5'd5 || ex.ex_alu_ctrl !== 4'b0000 || ex.ex_reg_write !== 1'b1 || ex.ex_result_src !== 2'b00)
         begin errors++; $display("FAIL add_decode got rd=%0d rs1=%0d alu=%b rw=%b rs=%b exp 6 5 0000 1 00", ex.ex_rd, ex.ex_rs1, ex.ex_alu_ctrl, ex.ex_reg_write, ex.ex_result_src); end
      checks++; if (ex.ex_pc !== 5'd4 || ex.ex_pc_next !== 5'd8) begin errors++; $display("FAIL pc_pass got %0d/%0d exp 4/8", ex.ex_pc, ex.ex_pc_next); end
      wb_en = 0; instr = enc_r(0, 5, 0, 0, 6);
      tick();
      checks++; if (ex.ex_rd2 !== 32'h1234 || ex.ex_rd1 !== 32'd0) begin errors++; $display("FAIL stored_read got rd2=%h rd1=%h exp 00001234 0", ex.ex_rd2, ex.ex_rd1); end
   endtask

   task automatic test_x0();
      idle();
      in_valid = 1; instr = enc_r(0, 0, 0, 0, 1);
      wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
      tick();
      checks++; if (ex.ex_rd1 !== 32'd0) begin errors++; $display("FAIL x0_bypass got %h exp 0", ex.ex_rd1); end
      wb_en = 0;
      tick();
      checks++; if (ex.ex_rd1 !== 32'd0) begin errors++; $display("FAIL x0_stored got %h exp 0", ex.ex_rd1); end
   endtask

   task automatic test_imm();
      idle();
      in_valid = 1;
      instr = enc_b(13'h1FF8, 2, 1);
      tick();
      checks++; if (ex.ex_imm !== 32'hFFFF_FFF8 || ex.ex_branch !== 1'b1 || ex.ex_alu_ctrl !== 4'b0001 || ex.ex_reg_write !== 1'b0)
         begin errors++; $display("FAIL beq got imm=%h br=%b alu=%b rw=%b exp fffffff8 1 0001 0", ex.ex_imm, ex.ex_branch, ex.ex_alu_ctrl, ex.ex_reg_write); end
      instr = {20'hABCDE, 5'd3, 7'b0110111};
      tick();
      checks++; if (ex.ex_imm !== 32'hABCD_E000 || ex.ex_result_src !== 2'b11 || ex.ex_reg_write !== 1'b1)
         begin errors++; $display("FAIL lui got imm=%h rs=%b rw=%b exp abcde000 11 1", ex.ex_imm, ex.ex_result_src, ex.ex_reg_write); end
      instr = enc_i(12'h403, 2, 3'b101, 1, 7'b0010011);
      tick();
      checks++; if (ex.ex_alu_ctrl !== 4'b0110 || ex.ex_alu_src !== 1'b1) begin errors++; $display("FAIL srai got alu=%b src=%b exp 0110 1", ex.ex_alu_ctrl, ex.ex_alu_src); end
      instr = enc_i(12'h003, 2, 3'b101, 1, 7'b0010011);
      tick();
      checks++; if (ex.ex_alu_ctrl !== 4'b0111) begin errors++; $display("FAIL srli got %b exp 0111", ex.ex_alu_ctrl); end
      instr = enc_i(12'h400, 2, 3'b000, 1, 7'b0010011);
      tick();
      checks++; if (ex.ex_alu_ctrl !== 4'b0000 || ex.ex_imm !== 32'h0000_0400) begin errors++; $display("FAIL addi_bit30 got alu=%b imm=%h exp 0000 00000400", ex.ex_alu_ctrl, ex.ex_imm); end
      instr = enc_r(7'b0100000, 3, 2, 3'b000, 1);
      tick();
      checks++; if (ex.ex_alu_ctrl !== 4'b0001) begin errors++; $display("FAIL sub got %b exp 0001", ex.ex_alu_ctrl); end
      instr = enc_r(7'b0000000, 3, 2, 3'b011, 1);
      tick();
      checks++; if (ex.ex_alu_ctrl !== 4'b1001 || ex.ex_funct3 !== 3'b011) begin errors++; $display("FAIL sltu got alu=%b f3=%b exp 1001 011", ex.ex_alu_ctrl, ex.ex_funct3); end
      instr = enc_s(12'hFFC, 2, 1);
      tick();
      checks++; if (ex.ex_imm !== 32'hFFFF_FFFC || ex.ex_mem_write !== 1'b1 || ex.ex_reg_write !== 1'b0 || ex.ex_alu_ctrl !== 4'b0000)
         begin errors++; $display("FAIL sw got imm=%h mw=%b rw=%b alu=%b exp fffffffc 1 0 0000", ex.ex_imm, ex.ex_mem_write, ex.ex_reg_write, ex.ex_alu_ctrl); end
      instr = enc_j(21'h000800, 1);
      tick();
      checks++; if (ex.ex_imm !== 32'h0000_0800 || ex.ex_jump !== 1'b1 || ex.ex_result_src !== 2'b10)
         begin errors++; $display("FAIL jal got imm=%h j=%b rs=%b exp 00000800 1 10", ex.ex_imm, ex.ex_jump, ex.ex_result_src); end
   endtask

   task automatic test_illegal();
      idle();
      in_valid = 1; instr = 32'hFFFF_FFFF;
      tick();
      checks++; if (ex.ex_illegal !== 1'b1 || ex.ex_reg_write !== 1'b0 || ex.ex_mem_write !== 1'b0 || ex.ex_branch !== 1'b0 || ex.ex_jump !== 1'b0)
         begin errors++; $display("FAIL illegal got il=%b rw=%b mw=%b br=%b j=%b exp 1 0 0 0 0", ex.ex_illegal, ex.ex_reg_write, ex.ex_mem_write, ex.ex_branch, ex.ex_jump); end
      checks++; if (ex.ex_imm !== 32'd0 || ex.ex_valid !== 1'b1) begin errors++; $display("FAIL illegal_imm got imm=%h v=%b exp 0 1", ex.ex_imm, ex.ex_valid); end
      in_valid = 0; instr = enc_r(0, 3, 2, 0, 1);
      tick();
      checks++; if (ex.ex_valid !== 1'b0 || ex.ex_reg_write !== 1'b0 || ex.ex_illegal !== 1'b0)
         begin errors++; $display("FAIL invalid_in got v=%b rw=%b il=%b exp 0 0 0", ex.ex_valid, ex.ex_reg_write, ex.ex_illegal); end
   endtask

   task automatic test_load_use();
      idle();
      in_valid = 1; instr = enc_i(12'd0, 1, 3'b010, 7, 7'b0000011);
      tick();
      checks++; if (ex.ex_result_src !== 2'b01 || ex.ex_rd !== 5'd7) begin errors++; $display("FAIL lw got rs=%b rd=%0d exp 01 7", ex.ex_result_src, ex.ex_rd); end
      instr = enc_i(12'd1, 7, 3'b000, 8, 7'b0010011);
      #1;
      checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL load_use_detect got %b exp 1", load_use_stall); end
      tick();
      checks++; if (ex.ex_valid !== 1'b0 || ex.ex_rd !== 5'd0 || load_use_stall !== 1'b0)
         begin errors++; $display("FAIL load_use_bubble got v=%b rd=%0d st=%b exp 0 0 0", ex.ex_valid, ex.ex_rd, load_use_stall); end
      tick();
      checks++; if (ex.ex_valid !== 1'b1 || ex.ex_rs1 !== 5'd7 || ex.ex_rd !== 5'd8 || ex.ex_imm !== 32'd1)
         begin errors++; $display("FAIL load_use_issue got v=%b rs1=%0d rd=%0d imm=%h exp 1 7 8 1", ex.ex_valid, ex.ex_rs1, ex.ex_rd, ex.ex_imm); end
      instr = enc_i(12'd0, 1, 3'b010, 7, 7'b0000011);
      tick();
      instr = enc_i(12'd1, 7, 3'b000, 8, 7'b0010011); flush = 1;
      #1;
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL flush_masks_stall got %b exp 0", load_use_stall); end
      tick();
      flush = 0; instr = enc_i(12'd0, 1, 3'b010, 7, 7'b0000011);
      tick();
      instr = {20'h00038, 5'd3, 7'b0110111};
      #1;
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lui_no_rs1 got %b exp 0", load_use_stall); end
      instr = enc_s(12'd0, 7, 2);
      #1;
      checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL sw_rs2_hazard got %b exp 1", load_use_stall); end
      tick();
   endtask

   task automatic test_stall_hold();
      idle();
      in_valid = 1; instr = enc_r(7'b0100000, 3, 2, 3'b000, 1);
      tick();
      instr = {20'h12345, 5'd4, 7'b0110111}; stall_in = 1;
      wb_en = 1; wb_addr = 9; wb_data = 32'h55;
      tick();
      checks++; if (ex.ex_alu_ctrl !== 4'b0001 || ex.ex_rd !== 5'd1 || ex.ex_valid !== 1'b1 || ex.ex_imm !== 32'd0)
         begin errors++; $display("FAIL stall_hold got alu=%b rd=%0d v=%b imm=%h exp 0001 1 1 0", ex.ex_alu_ctrl, ex.ex_rd, ex.ex_valid, ex.ex_imm); end
      stall_in = 0; wb_en = 0; instr = enc_r(0, 0, 9, 0, 1);
      tick();
      checks++; if (ex.ex_rd1 !== 32'h55) begin errors++; $display("FAIL write_during_stall got %h exp 00000055", ex.ex_rd1); end
   endtask

   task automatic test_flush_stall();
      idle();
      in_valid = 1; instr = enc_r(0, 0, 5, 0, 6);
      tick();
      flush = 1; stall_in = 1;
      tick();
      checks++; if (ex.ex_valid !== 1'b0 || ex.ex_reg_write !== 1'b0 || ex.ex_rd1 !== 32'd0 || ex.ex_rd !== 5'd0 || ex.ex_rs1 !== 5'd0)
         begin errors++; $display("FAIL flush_over_stall got v=%b rw=%b rd1=%h rd=%0d rs1=%0d exp all 0", ex.ex_valid, ex.ex_reg_write, ex.ex_rd1, ex.ex_rd, ex.ex_rs1); end
   endtask

   task automatic test_reset_mid_stall();
      idle();
      in_valid = 1; instr = enc_i(12'd0, 1, 3'b010, 7, 7'b0000011);
      tick();
      instr = enc_i(12'd1, 7, 3'b000, 8, 7'b0010011);
      #1;
      checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got %b exp 1", load_use_stall); end
      reset = 1; stall_in = 1;
      tick();
      checks++; if (ex.ex_valid !== 1'b0 || ex.ex_result_src !== 2'b00 || ex.ex_rd !== 5'd0 || ex.ex_alu_src !== 1'b0 || load_use_stall !== 1'b0)
         begin errors++; $display("FAIL reset_mid_stall got v=%b rs=%b rd=%0d src=%b st=%b exp all 0", ex.ex_valid, ex.ex_result_src, ex.ex_rd, ex.ex_alu_src, load_use_stall); end
      idle();
      in_valid = 1; instr = enc_r(0, 0, 9, 0, 1);
      tick();
      checks++; if (ex.ex_rd1 !== 32'd0) begin errors++; $display("FAIL reset_clears_regs got %h exp 0", ex.ex_rd1); end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_x0();
      test_imm();
      test_illegal();
      test_load_use();
      test_stall_hold();
      test_flush_stall();
      test_reset_mid_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
